// File: rtl/entrada_coordenadas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : entrada_coordenadas_pkg
// Purpose  : Shared state encoding, one-hot constants and cursor helpers for
//            the coordinate entry controller.
// Revision : 1.0 - initial release
// ============================================================================
package entrada_coordenadas_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    MANUAL  = 3'd1,
    SEL_ROW = 3'd2,
    SEL_COL = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic [2:0] OH_0    = 3'b100;
  localparam logic [2:0] OH_1    = 3'b010;
  localparam logic [2:0] OH_2    = 3'b001;
  localparam logic [2:0] OH_NONE = 3'b000;

  // Cursor index to one-hot line; the unreachable index 3 decodes as 0.
  function automatic logic [2:0] cursor_to_oh(input logic [1:0] cur);
    case (cur)
      2'd1:    cursor_to_oh = OH_1;
      2'd2:    cursor_to_oh = OH_2;
      default: cursor_to_oh = OH_0;
    endcase
  endfunction

  // Rotate 0->1->2->0; an index of 3 is treated as 0 and therefore moves to 1.
  function automatic logic [1:0] cursor_rotate(input logic [1:0] cur);
    case (cur)
      2'd1:    cursor_rotate = 2'd2;
      2'd2:    cursor_rotate = 2'd0;
      default: cursor_rotate = 2'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/entrada_coordenadas_debounce.sv
`default_nettype none
// ============================================================================
// Module   : botao_debounce
// Purpose  : Two-flop synchronizer, stable-sample debounce counter and
//            one-cycle press pulse on each debounced rising level.
// Revision : 1.0 - initial release
// ============================================================================
module botao_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a level change after enough consecutive differing samples; the
  // pulse fires in the same edge the level goes high, releases stay silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        pulse <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/entrada_coordenadas.sv
`default_nettype none
// ============================================================================
// Module   : entrada_coordenadas
// Purpose  : Button-driven mode / row / column entry controller producing
//            registered, always-legal decoder selection lines.
// Revision : 1.0 - initial release
// ============================================================================
module entrada_coordenadas
  import entrada_coordenadas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_ok,
  input  logic       btn_cancel,
  output logic       mode_a,
  output logic       mode_b,
  output logic [2:0] row_oh,
  output logic [2:0] col_oh,
  output logic       valid,
  output logic       commit
);

  logic p_mode, p_next, p_ok, p_cancel;

  botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .raw(btn_mode), .pulse(p_mode));
  botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst_n(rst_n), .raw(btn_next), .pulse(p_next));
  botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ok (
    .clk(clk), .rst_n(rst_n), .raw(btn_ok), .pulse(p_ok));
  botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
    .clk(clk), .rst_n(rst_n), .raw(btn_cancel), .pulse(p_cancel));

  state_t     state, state_n;
  logic [1:0] row_cur, row_n;
  logic [1:0] col_cur, col_n;
  logic       mode_a_n, mode_b_n, valid_n, commit_n;
  logic [2:0] row_oh_n, col_oh_n;

  // Next state, cursors and the output values derived from the next state.
  always_comb begin
    state_n = state;
    row_n   = row_cur;
    col_n   = col_cur;

    // Only the highest-priority press acts: mode > cancel > ok > next.
    if (p_mode) begin
      case (state)
        OFF:     state_n = MANUAL;
        MANUAL: begin
          state_n = SEL_ROW;
          row_n   = 2'd0;
        end
        default: begin
          state_n = OFF;
          row_n   = 2'd0;
          col_n   = 2'd0;
        end
      endcase
    end else if (p_cancel) begin
      case (state)
        HOLD:    state_n = SEL_COL;
        SEL_COL: state_n = SEL_ROW;
        SEL_ROW: state_n = MANUAL;
        default: state_n = state;
      endcase
    end else if (p_ok) begin
      case (state)
        SEL_ROW: begin
          state_n = SEL_COL;
          col_n   = 2'd0;
        end
        SEL_COL: state_n = HOLD;
        default: state_n = state;
      endcase
    end else if (p_next) begin
      case (state)
        SEL_ROW: row_n = cursor_rotate(row_cur);
        SEL_COL: col_n = cursor_rotate(col_cur);
        default: ;
      endcase
    end

    mode_a_n = 1'b0;
    mode_b_n = 1'b0;
    row_oh_n = OH_NONE;
    col_oh_n = OH_NONE;
    valid_n  = 1'b0;
    case (state_n)
      MANUAL:  mode_b_n = 1'b1;
      SEL_ROW: begin
        mode_a_n = 1'b1;
        row_oh_n = cursor_to_oh(row_n);
      end
      SEL_COL: begin
        mode_a_n = 1'b1;
        row_oh_n = cursor_to_oh(row_n);
        col_oh_n = cursor_to_oh(col_n);
      end
      HOLD: begin
        mode_a_n = 1'b1;
        row_oh_n = cursor_to_oh(row_n);
        col_oh_n = cursor_to_oh(col_n);
        valid_n  = 1'b1;
      end
      default: ;
    endcase
    commit_n = (state_n == HOLD) && (state != HOLD);
  end

  // State, cursors and every output are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OFF;
      row_cur <= 2'd0;
      col_cur <= 2'd0;
      mode_a  <= 1'b0;
      mode_b  <= 1'b0;
      row_oh  <= OH_NONE;
      col_oh  <= OH_NONE;
      valid   <= 1'b0;
      commit  <= 1'b0;
    end else begin
      state   <= state_n;
      row_cur <= row_n;
      col_cur <= col_n;
      mode_a  <= mode_a_n;
      mode_b  <= mode_b_n;
      row_oh  <= row_oh_n;
      col_oh  <= col_oh_n;
      valid   <= valid_n;
      commit  <= commit_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_entrada_coordenadas.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_entrada_coordenadas
// Purpose  : Self-checking bench for the coordinate entry controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_entrada_coordenadas;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_next = 1'b0, btn_ok = 1'b0, btn_cancel = 1'b0;
  logic       mode_a, mode_b, valid, commit;
  logic [2:0] row_oh, col_oh;

  localparam logic [3:0] B_MODE   = 4'b1000;
  localparam logic [3:0] B_CANCEL = 4'b0100;
  localparam logic [3:0] B_OK     = 4'b0010;
  localparam logic [3:0] B_NEXT   = 4'b0001;

  always #5 clk = ~clk;

  entrada_coordenadas #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_ok(btn_ok), .btn_cancel(btn_cancel),
    .mode_a(mode_a), .mode_b(mode_b), .row_oh(row_oh), .col_oh(col_oh),
    .valid(valid), .commit(commit)
  );

  typedef struct packed {
    logic       ma;
    logic       mb;
    logic [2:0] row;
    logic [2:0] col;
    logic       vld;
  } exp_t;

  exp_t sb[$];
  exp_t prev, mon_cur, mon_exp;
  int   n_cmp = 0;
  int   n_err = 0;
  int   commit_cnt = 0;
  bit   mon_en = 1'b0;

  function automatic exp_t mk(logic ma, logic mb, logic [2:0] row, logic [2:0] col, logic vld);
    exp_t e;
    e.ma = ma; e.mb = mb; e.row = row; e.col = col; e.vld = vld;
    return e;
  endfunction

  // Output monitor: every change of the selection bundle consumes one expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur.ma  = mode_a;
      mon_cur.mb  = mode_b;
      mon_cur.row = row_oh;
      mon_cur.col = col_oh;
      mon_cur.vld = valid;
      if (mon_cur !== prev) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change got ma=%b mb=%b row=%b col=%b vld=%b", mon_cur.ma, mon_cur.mb, mon_cur.row, mon_cur.col, mon_cur.vld);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_cur !== mon_exp) begin
            n_err++;
            $display("FAIL outputs got ma=%b mb=%b row=%b col=%b vld=%b want ma=%b mb=%b row=%b col=%b vld=%b",
                     mon_cur.ma, mon_cur.mb, mon_cur.row, mon_cur.col, mon_cur.vld,
                     mon_exp.ma, mon_exp.mb, mon_exp.row, mon_exp.col, mon_exp.vld);
          end
        end
        if (!prev.vld && mon_cur.vld) begin
          n_cmp++;
          if (commit !== 1'b1) begin
            n_err++;
            $display("FAIL commit_on_valid_rise got %b want 1", commit);
          end
        end
        prev = mon_cur;
      end
      if (commit === 1'b1) begin
        commit_cnt++;
        n_cmp++;
        if (valid !== 1'b1) begin
          n_err++;
          $display("FAIL commit_without_valid got valid=%b want 1", valid);
        end
      end
    end
  end

  task automatic press(input logic [3:0] b, input int hold);
    @(negedge clk);
    {btn_mode, btn_cancel, btn_ok, btn_next} = b;
    repeat (hold) @(negedge clk);
    {btn_mode, btn_cancel, btn_ok, btn_next} = 4'b0000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({mode_a, mode_b, row_oh, col_oh, valid, commit} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_outputs got %b want 0", {mode_a, mode_b, row_oh, col_oh, valid, commit});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    prev = '0;
    mon_en = 1'b1;
  endtask

  task automatic test_full_entry;
    int c0;
    c0 = commit_cnt;
    sb.push_back(mk(0, 1, 3'b000, 3'b000, 0)); press(B_MODE, 10);
    sb.push_back(mk(1, 0, 3'b100, 3'b000, 0)); press(B_MODE, 10);
    sb.push_back(mk(1, 0, 3'b010, 3'b000, 0)); press(B_NEXT, 10);
    sb.push_back(mk(1, 0, 3'b010, 3'b100, 0)); press(B_OK, 10);
    sb.push_back(mk(1, 0, 3'b010, 3'b010, 0)); press(B_NEXT, 10);
    sb.push_back(mk(1, 0, 3'b010, 3'b001, 0)); press(B_NEXT, 10);
    sb.push_back(mk(1, 0, 3'b010, 3'b001, 1)); press(B_OK, 10);
    #1;
    n_cmp++;
    if (commit_cnt - c0 != 1) begin
      n_err++;
      $display("FAIL full_entry_commit_cycles got %0d want 1", commit_cnt - c0);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL full_entry_pending got %0d want 0", sb.size());
    end
  endtask

  task automatic test_cancel;
    sb.push_back(mk(1, 0, 3'b010, 3'b001, 0)); press(B_CANCEL, 10);
    sb.push_back(mk(1, 0, 3'b010, 3'b000, 0)); press(B_CANCEL, 10);
    sb.push_back(mk(0, 1, 3'b000, 3'b000, 0)); press(B_CANCEL, 10);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL cancel_pending got %0d want 0", sb.size());
    end
  endtask

  task automatic test_wrap;
    sb.push_back(mk(1, 0, 3'b100, 3'b000, 0)); press(B_MODE, 10);
    sb.push_back(mk(1, 0, 3'b010, 3'b000, 0)); press(B_NEXT, 10);
    sb.push_back(mk(1, 0, 3'b001, 3'b000, 0)); press(B_NEXT, 10);
    sb.push_back(mk(1, 0, 3'b100, 3'b000, 0)); press(B_NEXT, 10);
    sb.push_back(mk(1, 0, 3'b100, 3'b100, 0)); press(B_OK, 10);
    sb.push_back(mk(1, 0, 3'b100, 3'b010, 0)); press(B_NEXT, 10);
    sb.push_back(mk(1, 0, 3'b100, 3'b001, 0)); press(B_NEXT, 10);
    sb.push_back(mk(1, 0, 3'b100, 3'b100, 0)); press(B_NEXT, 10);
    #1;
    n_cmp++;
    if (row_oh !== 3'b100 || col_oh !== 3'b100) begin
      n_err++;
      $display("FAIL wrap_final got row=%b col=%b want row=100 col=100", row_oh, col_oh);
    end
  endtask

  task automatic test_bounce;
    press(B_NEXT, 3);
    #1;
    n_cmp++;
    if (col_oh !== 3'b100) begin
      n_err++;
      $display("FAIL glitch_rejected got col=%b want 100", col_oh);
    end
    sb.push_back(mk(1, 0, 3'b100, 3'b010, 0)); press(B_NEXT, 20);
    #1;
    n_cmp++;
    if (col_oh !== 3'b010 || sb.size() != 0) begin
      n_err++;
      $display("FAIL long_hold_single got col=%b pending=%0d want col=010 pending=0", col_oh, sb.size());
    end
  endtask

  task automatic test_priority;
    int c0;
    sb.push_back(mk(1, 0, 3'b100, 3'b000, 0)); press(B_OK | B_CANCEL, 10);
    #1;
    n_cmp++;
    if (valid !== 1'b0 || col_oh !== 3'b000) begin
      n_err++;
      $display("FAIL ok_cancel_priority got valid=%b col=%b want valid=0 col=000", valid, col_oh);
    end
    c0 = commit_cnt;
    sb.push_back(mk(1, 0, 3'b100, 3'b100, 0)); press(B_OK, 10);
    sb.push_back(mk(1, 0, 3'b100, 3'b100, 1)); press(B_OK, 10);
    sb.push_back(mk(0, 0, 3'b000, 3'b000, 0)); press(B_MODE | B_NEXT, 10);
    #1;
    n_cmp++;
    if (commit_cnt - c0 != 1 || {mode_a, mode_b, row_oh, col_oh, valid, commit} !== 10'b0) begin
      n_err++;
      $display("FAIL mode_priority_off got commits=%0d outs=%b want commits=1 outs=0",
               commit_cnt - c0, {mode_a, mode_b, row_oh, col_oh, valid, commit});
    end
  endtask

  task automatic test_reset_mid;
    sb.push_back(mk(0, 1, 3'b000, 3'b000, 0)); press(B_MODE, 10);
    sb.push_back(mk(1, 0, 3'b100, 3'b000, 0)); press(B_MODE, 10);
    sb.push_back(mk(1, 0, 3'b100, 3'b100, 0)); press(B_OK, 10);
    sb.push_back(mk(1, 0, 3'b100, 3'b100, 1)); press(B_OK, 10);
    @(negedge clk);
    #2;
    sb.push_back(mk(0, 0, 3'b000, 3'b000, 0));
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mode_a, mode_b, row_oh, col_oh, valid, commit} !== 10'b0) begin
      n_err++;
      $display("FAIL async_reset_mid_hold got %b want 0", {mode_a, mode_b, row_oh, col_oh, valid, commit});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back(mk(0, 1, 3'b000, 3'b000, 0));
    btn_mode = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (mode_b !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early got mode_b=%b want 0 after 6 edges", mode_b);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (mode_b !== 1'b1) begin
      n_err++;
      $display("FAIL latency_7 got mode_b=%b want 1 after 7 edges", mode_b);
    end
    @(negedge clk);
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_pending got %0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_full_entry;
    test_cancel;
    test_wrap;
    test_bounce;
    test_priority;
    test_reset_mid;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
